// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32I control definitions: opcode constants, per-stage control
// bundles and the single-point decode function used by the pipe and by
// trace checkers.
package rv32_ctrl_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned REG_W = 5;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  // EX-stage controls plus the opcode class flags redirect/hazard need
  typedef struct packed {
    logic [1:0] alu_mux;
    logic       se2_ctrl;
    logic       csrw_mux;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       is_load;
  } ex_ctrl_t;

  typedef struct packed {
    logic [3:0] wbyteen;
    logic [1:0] rbyteen;
    logic [1:0] dm_mux;
  } mem_ctrl_t;

  typedef struct packed {
    logic       wren_rf;
    logic [1:0] wd_mux;
    logic [1:0] branch_mux;
  } wb_ctrl_t;

  // What remains in flight once EX controls have been consumed
  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } memwb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_bundle_t;

  typedef struct packed {
    logic         legal;
    ctrl_bundle_t ctrl;
  } decode_t;

  // Decode one instruction; illegal encodings return an all-zero bundle
  function automatic decode_t decode_ctrl(
    input logic [OPC_W-1:0] opcode,
    input logic [F3_W-1:0]  funct3,
    input logic [REG_W-1:0] rd,
    input logic             csr_en
  );
    decode_t d;
    logic lui, auipc, jal, jalr, branch, load, store, opimm, op, system;
    lui    = (opcode == OPC_LUI);
    auipc  = (opcode == OPC_AUIPC);
    jal    = (opcode == OPC_JAL);
    jalr   = (opcode == OPC_JALR);
    branch = (opcode == OPC_BRANCH);
    load   = (opcode == OPC_LOAD);
    store  = (opcode == OPC_STORE);
    opimm  = (opcode == OPC_OPIMM);
    op     = (opcode == OPC_OP);
    system = (opcode == OPC_SYSTEM);

    d = '0;
    // Stores wider than a word have no byte-enable encoding
    d.legal = lui | auipc | jal | jalr | branch | load | op | opimm
            | (store & (funct3 <= 3'd2)) | (system & csr_en);

    d.ctrl.wb.wren_rf       = ~branch & ~store & (rd != '0);
    d.ctrl.wb.wd_mux        = {auipc, lui};
    d.ctrl.wb.branch_mux[0] = lui | auipc | jal;
    d.ctrl.wb.branch_mux[1] = jalr | load | jal;

    d.ctrl.ex.alu_mux[0] = (opimm & (funct3[1:0] == 2'b01)) | store | branch;
    d.ctrl.ex.alu_mux[1] = jalr | load | opimm | store | branch;
    d.ctrl.ex.se2_ctrl   = branch;
    d.ctrl.ex.csrw_mux   = system & funct3[2];
    d.ctrl.ex.is_jal     = jal;
    d.ctrl.ex.is_jalr    = jalr;
    d.ctrl.ex.is_branch  = branch;
    d.ctrl.ex.is_load    = load;

    d.ctrl.mem.dm_mux[0] = load & ((funct3 == 3'b010) | (funct3[2:1] == 2'b10));
    d.ctrl.mem.dm_mux[1] = load & ~funct3[1];
    d.ctrl.mem.rbyteen   = load ? funct3[1:0] : 2'b00;
    if (store) begin
      case (funct3)
        3'd0:    d.ctrl.mem.wbyteen = 4'b0001;
        3'd1:    d.ctrl.mem.wbyteen = 4'b0011;
        3'd2:    d.ctrl.mem.wbyteen = 4'b1111;
        default: d.ctrl.mem.wbyteen = 4'b0000;
      endcase
    end

    if (!d.legal) d.ctrl = '0;
    return d;
  endfunction

  // rs1 is read by everything except upper-immediate, JAL and CSR-immediate forms
  function automatic logic uses_rs1(
    input logic [OPC_W-1:0] opcode,
    input logic [F3_W-1:0]  funct3
  );
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL)
             || ((opcode == OPC_SYSTEM) && funct3[2]));
  endfunction

  function automatic logic uses_rs2(input logic [OPC_W-1:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational decode-slot control generation.
// Ports: i_valid/i_opcode/i_funct3/i_rd  - decode-slot instruction
//        o_ctrl_c   - control bundle (zero unless o_valid_c)
//        o_valid_c  - real, legal instruction
//        o_rs1_used_c/o_rs2_used_c - source-register usage for interlock
module ctrl_decode
  import rv32_ctrl_pkg::*;
#(
  parameter bit CSR_EN = 1'b1
) (
  input  logic             i_valid,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [F3_W-1:0]  i_funct3,
  input  logic [REG_W-1:0] i_rd,
  output ctrl_bundle_t     o_ctrl_c,
  output logic             o_valid_c,
  output logic             o_rs1_used_c,
  output logic             o_rs2_used_c
);

  decode_t w_dec;

  always_comb begin
    w_dec        = decode_ctrl(i_opcode, i_funct3, i_rd, CSR_EN);
    o_valid_c    = i_valid & w_dec.legal;
    o_ctrl_c     = o_valid_c ? w_dec.ctrl : '0;
    o_rs1_used_c = uses_rs1(i_opcode, i_funct3);
    o_rs2_used_c = uses_rs2(i_opcode);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined RV32I control unit: EX/MEM/WB control registers, redirect
// flush and load-use interlock.
// Ports: clk, reset (sync, active-high), stall_in (global freeze)
//        id_*        - decode-slot instruction fields
//        take_branch - branch outcome for the instruction in EX
//        ex_*/mem_*/wb_* - per-stage datapath controls
//        flush, hazard_stall - combinational redirect / load-use hold
module ctrl_pipe
  import rv32_ctrl_pkg::*;
#(
  parameter bit CSR_EN       = 1'b1,
  parameter bit INTERLOCK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [F3_W-1:0]  id_funct3,
  input  logic [REG_W-1:0] id_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             take_branch,
  output logic [1:0]       ex_alu_mux,
  output logic             ex_se2_ctrl,
  output logic             ex_csrw_mux,
  output logic             ex_pc_mux,
  output logic [3:0]       mem_wbyteen,
  output logic [1:0]       mem_rbyteen,
  output logic [1:0]       mem_dm_mux,
  output logic             wb_wren_rf,
  output logic [1:0]       wb_wd_mux,
  output logic [1:0]       wb_branch_mux,
  output logic             flush,
  output logic             hazard_stall
);

  ctrl_bundle_t     w_id_ctrl;
  logic             w_id_valid;
  logic             w_rs1_used;
  logic             w_rs2_used;
  logic             w_flush;
  logic             w_load_hit;
  logic             w_hazard;

  logic             r_ex_valid;
  ctrl_bundle_t     r_ex_ctrl;
  logic [REG_W-1:0] r_ex_rd;
  logic             r_mem_valid;
  memwb_ctrl_t      r_mem_ctrl;
  logic             r_wb_valid;
  wb_ctrl_t         r_wb_ctrl;

  ctrl_decode #(.CSR_EN(CSR_EN)) u_decode (
    .i_valid      (id_valid),
    .i_opcode     (id_opcode),
    .i_funct3     (id_funct3),
    .i_rd         (id_rd),
    .o_ctrl_c     (w_id_ctrl),
    .o_valid_c    (w_id_valid),
    .o_rs1_used_c (w_rs1_used),
    .o_rs2_used_c (w_rs2_used)
  );

  // Redirect from the jump/taken branch currently in EX
  assign w_flush = r_ex_valid & (r_ex_ctrl.ex.is_jal | r_ex_ctrl.ex.is_jalr
                                 | (r_ex_ctrl.ex.is_branch & take_branch));

  // Load in EX whose destination is read by the decode-slot instruction
  assign w_load_hit = r_ex_valid & r_ex_ctrl.ex.is_load & (r_ex_rd != '0) & id_valid
                    & ((w_rs1_used & (id_rs1 == r_ex_rd))
                       | (w_rs2_used & (id_rs2 == r_ex_rd)));

  // A redirect discards the dependent instruction, so it overrides the stall
  assign w_hazard = INTERLOCK_EN & w_load_hit & ~w_flush;

  // Stage registers: freeze on stall_in, bubble into EX on flush/stall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= '0;
      r_ex_rd     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_ctrl  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_ctrl   <= '0;
    end else if (!stall_in) begin
      r_wb_valid     <= r_mem_valid;
      r_wb_ctrl      <= r_mem_ctrl.wb;
      r_mem_valid    <= r_ex_valid;
      r_mem_ctrl.mem <= r_ex_ctrl.mem;
      r_mem_ctrl.wb  <= r_ex_ctrl.wb;
      if (w_flush || w_hazard) begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= '0;
        r_ex_rd    <= '0;
      end else begin
        r_ex_valid <= w_id_valid;
        r_ex_ctrl  <= w_id_ctrl;
        r_ex_rd    <= id_rd;
      end
    end
  end

  assign ex_alu_mux    = r_ex_ctrl.ex.alu_mux & {2{r_ex_valid}};
  assign ex_se2_ctrl   = r_ex_ctrl.ex.se2_ctrl & r_ex_valid;
  assign ex_csrw_mux   = r_ex_ctrl.ex.csrw_mux & r_ex_valid;
  assign ex_pc_mux     = w_flush;
  assign mem_wbyteen   = r_mem_ctrl.mem.wbyteen & {4{r_mem_valid}};
  assign mem_rbyteen   = r_mem_ctrl.mem.rbyteen & {2{r_mem_valid}};
  assign mem_dm_mux    = r_mem_ctrl.mem.dm_mux & {2{r_mem_valid}};
  assign wb_wren_rf    = r_wb_ctrl.wren_rf & r_wb_valid;
  assign wb_wd_mux     = r_wb_ctrl.wd_mux & {2{r_wb_valid}};
  assign wb_branch_mux = r_wb_ctrl.branch_mux & {2{r_wb_valid}};
  assign flush         = w_flush;
  assign hazard_stall  = w_hazard;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe with a per-stage expectation queue.
module tb_ctrl_pipe;

  typedef enum int {K_NONE, K_ADDI, K_SB, K_SW, K_LH, K_LW5, K_LW0, K_ADD,
                    K_LUI7, K_BEQ, K_JAL, K_CSR, K_ILL} kind_e;

  // ex = {alu_mux, se2, csrw}; mem = {wbyteen, rbyteen, dm_mux}; wb = {wren, wd_mux, branch_mux}
  typedef struct packed {
    logic [3:0] ex;
    logic [7:0] mem;
    logic [4:0] wb;
  } rec_t;

  logic       clk, reset, stall_in, id_valid, take_branch;
  logic [6:0] id_opcode;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;

  logic [1:0] ex_alu_mux, mem_rbyteen, mem_dm_mux, wb_wd_mux, wb_branch_mux;
  logic       ex_se2_ctrl, ex_csrw_mux, ex_pc_mux, wb_wren_rf, flush, hazard_stall;
  logic [3:0] mem_wbyteen;

  logic [1:0] n_alu, n_rbyteen, n_dm, n_wd, n_bm;
  logic       n_se2, n_csrw, n_pcmux, n_wren, n_flush, n_hz;
  logic [3:0] n_wbyteen;

  int   checks = 0;
  int   errors = 0;
  int   step = 0;
  bit   chk2 = 0;
  rec_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .take_branch(take_branch),
    .ex_alu_mux(ex_alu_mux), .ex_se2_ctrl(ex_se2_ctrl), .ex_csrw_mux(ex_csrw_mux),
    .ex_pc_mux(ex_pc_mux), .mem_wbyteen(mem_wbyteen), .mem_rbyteen(mem_rbyteen),
    .mem_dm_mux(mem_dm_mux), .wb_wren_rf(wb_wren_rf), .wb_wd_mux(wb_wd_mux),
    .wb_branch_mux(wb_branch_mux), .flush(flush), .hazard_stall(hazard_stall)
  );

  ctrl_pipe #(.CSR_EN(1'b0)) dut_nocsr (
    .clk(clk), .reset(reset), .stall_in(stall_in), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .take_branch(take_branch),
    .ex_alu_mux(n_alu), .ex_se2_ctrl(n_se2), .ex_csrw_mux(n_csrw),
    .ex_pc_mux(n_pcmux), .mem_wbyteen(n_wbyteen), .mem_rbyteen(n_rbyteen),
    .mem_dm_mux(n_dm), .wb_wren_rf(n_wren), .wb_wd_mux(n_wd),
    .wb_branch_mux(n_bm), .flush(n_flush), .hazard_stall(n_hz)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, step, obs, exp);
    end
  endtask

  // Hand-derived expected controls per instruction
  function automatic rec_t rec_of(input kind_e k);
    rec_t r;
    r = '0;
    case (k)
      K_ADDI: begin r.ex = 4'b1000; r.wb = 5'b10000; end
      K_SB:   begin r.ex = 4'b1100; r.mem = 8'b0001_00_00; end
      K_SW:   begin r.ex = 4'b1100; r.mem = 8'b1111_00_00; end
      K_LH:   begin r.ex = 4'b1000; r.mem = 8'b0000_01_10; r.wb = 5'b1_00_10; end
      K_LW5:  begin r.ex = 4'b1000; r.mem = 8'b0000_10_01; r.wb = 5'b1_00_10; end
      K_LW0:  begin r.ex = 4'b1000; r.mem = 8'b0000_10_01; r.wb = 5'b0_00_10; end
      K_ADD:  r.wb = 5'b1_00_00;
      K_LUI7: r.wb = 5'b1_01_01;
      K_BEQ:  r.ex = 4'b1110;
      K_JAL:  r.wb = 5'b1_00_11;
      K_CSR:  begin r.ex = 4'b0001; r.wb = 5'b1_00_00; end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic drive(input kind_e k);
    id_valid = 1'b1; id_funct3 = 3'd0; id_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    case (k)
      K_NONE: begin id_valid = 1'b0; id_opcode = 7'b0010011; end
      K_ADDI: begin id_opcode = 7'b0010011; id_rd = 5'd9; id_rs1 = 5'd1; end
      K_SB:   begin id_opcode = 7'b0100011; id_rs1 = 5'd2; id_rs2 = 5'd3; end
      K_SW:   begin id_opcode = 7'b0100011; id_funct3 = 3'd2; id_rs1 = 5'd2; id_rs2 = 5'd5; end
      K_LH:   begin id_opcode = 7'b0000011; id_funct3 = 3'd1; id_rd = 5'd8; id_rs1 = 5'd2; end
      K_LW5:  begin id_opcode = 7'b0000011; id_funct3 = 3'd2; id_rd = 5'd5; id_rs1 = 5'd2; end
      K_LW0:  begin id_opcode = 7'b0000011; id_funct3 = 3'd2; id_rd = 5'd0; id_rs1 = 5'd2; end
      K_ADD:  begin id_opcode = 7'b0110011; id_rd = 5'd6; id_rs1 = 5'd5; id_rs2 = 5'd1; end
      K_LUI7: begin id_opcode = 7'b0110111; id_rd = 5'd7; id_rs1 = 5'd5; id_rs2 = 5'd5; end
      K_BEQ:  begin id_opcode = 7'b1100011; id_rs1 = 5'd1; id_rs2 = 5'd2; end
      K_JAL:  begin id_opcode = 7'b1101111; id_rd = 5'd1; id_rs1 = 5'd5; id_rs2 = 5'd5; end
      K_CSR:  begin id_opcode = 7'b1110011; id_funct3 = 3'b101; id_rd = 5'd3; id_rs1 = 5'd5; end
      default: begin id_opcode = 7'b0000000; id_rd = 5'd4; end
    endcase
  endtask

  task automatic check_cycle(input bit ef, input bit eh);
    chk("ex_ctrl", {4'b0, ex_alu_mux, ex_se2_ctrl, ex_csrw_mux}, {4'b0, q[2].ex});
    chk("mem_ctrl", {mem_wbyteen, mem_rbyteen, mem_dm_mux}, q[1].mem);
    chk("wb_ctrl", {3'b0, wb_wren_rf, wb_wd_mux, wb_branch_mux}, {3'b0, q[0].wb});
    chk("flush", {7'b0, flush}, {7'b0, ef});
    chk("ex_pc_mux", {7'b0, ex_pc_mux}, {7'b0, ef});
    chk("hazard_stall", {7'b0, hazard_stall}, {7'b0, eh});
    if (chk2) begin
      chk("nocsr_ex_csrw", {7'b0, n_csrw}, 8'h00);
      chk("nocsr_mem", {n_wbyteen, n_rbyteen, n_dm}, 8'h00);
      chk("nocsr_wb_wren", {7'b0, n_wren}, 8'h00);
    end
  endtask

  // One cycle: drive decode slot, check mid-cycle, then advance the model
  task automatic cyc(input kind_e k, input bit ef, input bit eh, input bit tb, input bit st);
    step++;
    stall_in = st; take_branch = tb;
    drive(k);
    @(negedge clk);
    check_cycle(ef, eh);
    @(posedge clk);
    if (!st) begin
      q.push_back((!ef && !eh) ? rec_of(k) : rec_t'('0));
      void'(q.pop_front());
    end
    #1;
  endtask

  task automatic do_reset();
    step++;
    reset = 1'b1; stall_in = 1'b0; take_branch = 1'b0;
    drive(K_ADDI);
    @(posedge clk); #1;
    q = {rec_t'('0), rec_t'('0), rec_t'('0)};
    @(negedge clk);
    check_cycle(1'b0, 1'b0);
    @(posedge clk); #1;
    q = {rec_t'('0), rec_t'('0), rec_t'('0)};
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; take_branch = 1'b0;
    drive(K_ADDI);
    do_reset();
    // first instruction lands in EX one edge after release
    cyc(K_ADDI, 0, 0, 0, 0);
    cyc(K_SB,   0, 0, 0, 0);
    cyc(K_LH,   0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    // taken then not-taken branch
    cyc(K_BEQ,  0, 0, 0, 0);
    cyc(K_ADDI, 1, 0, 1, 0);
    cyc(K_ADDI, 0, 0, 0, 0);
    cyc(K_BEQ,  0, 0, 0, 0);
    cyc(K_ADDI, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 1, 0);
    // load-use on rs1, then non-dependent followers
    cyc(K_LW5,  0, 0, 0, 0);
    cyc(K_ADD,  0, 1, 0, 0);
    cyc(K_ADD,  0, 0, 0, 0);
    cyc(K_LW5,  0, 0, 0, 0);
    cyc(K_LUI7, 0, 0, 0, 0);
    cyc(K_LW0,  0, 0, 0, 0);
    cyc(K_ADD,  0, 0, 0, 0);
    // load-use on rs2
    cyc(K_LW5,  0, 0, 0, 0);
    cyc(K_SW,   0, 1, 0, 0);
    cyc(K_SW,   0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    // JAL redirects unconditionally
    cyc(K_JAL,  0, 0, 0, 0);
    cyc(K_ADDI, 1, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    // freeze mid-stream
    cyc(K_LH,   0, 0, 0, 0);
    cyc(K_SB,   0, 0, 0, 0);
    cyc(K_ADDI, 0, 0, 0, 1);
    cyc(K_ADDI, 0, 0, 0, 1);
    cyc(K_ADDI, 0, 0, 0, 1);
    cyc(K_ADDI, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    // freeze while a load-use stall is pending
    cyc(K_LW5,  0, 0, 0, 0);
    cyc(K_ADD,  0, 1, 0, 1);
    cyc(K_ADD,  0, 1, 0, 1);
    cyc(K_ADD,  0, 1, 0, 0);
    cyc(K_ADD,  0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    // CSR write and illegal opcode, also against the CSR-disabled instance
    chk2 = 1'b1;
    cyc(K_CSR,  0, 0, 0, 0);
    cyc(K_ILL,  0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    chk2 = 1'b0;
    // reset mid-operation discards in-flight work
    cyc(K_ADDI, 0, 0, 0, 0);
    cyc(K_SB,   0, 0, 0, 0);
    do_reset();
    cyc(K_NONE, 0, 0, 0, 0);
    cyc(K_NONE, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined RV32I control unit for the 3-stage datapath (EX, MEM, WB) following instruction fetch/decode. It decodes `opcode`/`funct3` once at decode, registers a control bundle per in-flight instruction, and presents each stage's mux and enable controls from that stage's own register. It also generates redirect flush and load-use interlock. All datapath mux encodings are unchanged from the existing single-stage decoder.

## Interface
- `CSR_EN`, default 1: 1 = decode SYSTEM (1110011) as CSR write; 0 = SYSTEM is illegal and becomes a bubble.
- `INTERLOCK_EN`, default 1: 1 = hardware load-use stall; 0 = no hazard check, `hazard_stall` is tied to 0.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `stall_in` in 1: external freeze, e.g. memory not ready.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_opcode` in 7, `id_funct3` in 3, `id_rd`/`id_rs1`/`id_rs2` in 5: decode-stage fields.
- `take_branch` in 1: branch comparison result for the instruction currently in EX.
- `ex_alu_mux` out 2, `ex_se2_ctrl` out 1, `ex_csrw_mux` out 1, `ex_pc_mux` out 1: EX controls.
- `mem_wbyteen` out 4, `mem_rbyteen` out 2, `mem_dm_mux` out 2: MEM controls.
- `wb_wren_rf` out 1, `wb_wd_mux` out 2, `wb_branch_mux` out 2: WB controls.
- `flush` out 1: kill the instruction in decode/fetch.
- `hazard_stall` out 1: hold PC and decode register.

## Operation
- **Decode.** Only when `id_valid` is 1 and the opcode is legal:
  - `wren` = not branch (1100011), not store (0100011), and `rd`≠0.
  - `wd_mux` = {AUIPC, LUI}.
  - `branch_mux[0]` = LUI|AUIPC|JAL; `branch_mux[1]` = JALR|load|JAL.
  - `alu_mux[0]` = (op-imm & funct3[1:0]==01) | store | branch; `alu_mux[1]` = JALR|load|op-imm|store|branch.
  - `dm_mux[0]` = load & (funct3==010 | funct3[2:1]==10); `dm_mux[1]` = load & !funct3[1].
  - `rbyteen` = funct3[1:0] on loads, else 0.
  - `wbyteen` on stores: funct3 0→0001, 1→0011, 2→1111; any other store funct3 is illegal.
  - `csrw_mux` = SYSTEM & funct3[2]; `se2` = branch.
- **Illegal opcode.** Any opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM} enters the pipe with valid=0.
- **Stage registers.** Each of EX, MEM, WB holds valid + bundle + rd. Every output is its stage field ANDed with that stage's valid.
- **Redirect.** `ex_pc_mux` = EX valid & (JAL | JALR | (branch & `take_branch`)). `flush` = `ex_pc_mux`. On the next edge a bubble enters EX in place of the decode-slot instruction.
- **Load-use** (INTERLOCK_EN=1). `hazard_stall` = EX valid load & EX rd≠0 & `id_valid` & ((rs1 used & rs1==EX rd) | (rs2 used & rs2==EX rd)).
  - rs1 is used by all opcodes except LUI, AUIPC, JAL, and SYSTEM with funct3[2]=1.
  - rs2 is used by BRANCH, STORE, OP.
  - On stall: a bubble enters EX, decode holds, and MEM/WB advance.
- **Priority per edge:** `reset` > `stall_in` (all stage registers hold, outputs stable) > redirect > load-use > normal advance.
- **Flush over hazard.** When redirect and load-use coincide, the flush wins and `hazard_stall` is forced to 0.

## Timing
- **Reset.** All stage valids are 0 on the first edge with `reset`=1, so every output is 0, including `flush` and `hazard_stall`. Reset mid-operation discards all in-flight instructions.
- **Latency.** An instruction in decode at edge N is in EX after N, in MEM after N+1, and in WB after N+2. No bypass.
- **Combinational outputs.** `flush`, `hazard_stall`, and `ex_pc_mux` are combinational from EX state, `take_branch`, and decode inputs, and are valid in the same cycle.
- **Stall length.** A load-use stall lasts exactly 1 cycle, since the load leaves EX on the next edge.
- **`stall_in` during a stall.** If `stall_in` is high while `hazard_stall` is high, the stall persists, frozen, until `stall_in` drops.

## Structure
- **Shared package `rv32_ctrl_pkg`:**
  - Opcode constants (OPC_LUI … OPC_SYSTEM).
  - Packed struct `ctrl_bundle_t` holding all bundle fields.
  - Function `decode_ctrl(opcode, funct3, rd, csr_en)` returning the bundle plus `legal`.
- **Sub-module `ctrl_decode`:** purely combinational decode, reused by the trace checker.
- **Top level:** the `ctrl_pipe` top holds the three stage registers and hazard/flush logic.

## Test plan
- **Reset:** assert `reset` 2 cycles with `id_valid`=1 → all outputs 0; first instruction reaches EX 1 cycle after release.
- **Store then load:** SB (funct3 000) then LH (funct3 001) → `mem_wbyteen`=0001 in cycle 2, then `mem_rbyteen`=01 and `mem_dm_mux`=10 the next cycle; `wb_wren_rf`=0 for SB, 1 for LH.
- **Taken branch:** BEQ in EX with `take_branch`=1 → `ex_pc_mux`=`flush`=1 for 1 cycle; next EX valid=0. Repeat with `take_branch`=0 → no flush.
- **Load-use:** LW x5 then ADD x6,x5,x1 → `hazard_stall`=1 for 1 cycle, bubble in EX, ADD reaches EX 1 cycle late.
  - LW x0 or LUI x7 after LW x5 → no stall.
- **Freeze:** `stall_in`=1 for 3 cycles mid-stream → all outputs constant; then resume with no lost or duplicated instruction.
- **Illegal / CSR_EN:** opcode 0000000 and (CSR_EN=0) CSRRWI → WB `wb_wren_rf`=0, all MEM outputs 0; with CSR_EN=1, CSRRWI gives `ex_csrw_mux`=1.
